// File: rtl/dtcm_arb.sv
// Two-port round-robin arbiter for the DTCM: LSU is port 0 and the external/debug master is port 1.
// An in-order FIFO of source IDs steers each DTCM response back to the master that issued the command.

module dtcm_arb_port #(
  parameter int DW      = 32,
  parameter int PORT_ID = 0
) (
  input  logic          win_id,
  input  logic          cmd_go,
  input  logic          head_id,
  input  logic          rsp_live,
  input  logic [DW-1:0] rsp_rdata_in,
  input  logic          rsp_ready_in,
  output logic          cmd_ready,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          sel_rsp_ready
);
  logic is_win, is_head;

  assign is_win        = (win_id == 1'(PORT_ID));
  assign is_head       = (head_id == 1'(PORT_ID));
  assign cmd_ready     = cmd_go & is_win;
  assign rsp_valid     = rsp_live & is_head;
  assign rsp_rdata     = rsp_valid ? rsp_rdata_in : '0;
  assign sel_rsp_ready = rsp_ready_in & is_head;
endmodule

module dtcm_arb #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int OUTS_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_cmd_valid,
  output logic            lsu_cmd_ready,
  input  logic            lsu_cmd_read,
  input  logic [AW-1:0]   lsu_cmd_addr,
  input  logic [DW-1:0]   lsu_cmd_wdata,
  input  logic [DW/8-1:0] lsu_cmd_wmask,
  output logic            lsu_rsp_valid,
  input  logic            lsu_rsp_ready,
  output logic [DW-1:0]   lsu_rsp_rdata,
  input  logic            ext_cmd_valid,
  output logic            ext_cmd_ready,
  input  logic            ext_cmd_read,
  input  logic [AW-1:0]   ext_cmd_addr,
  input  logic [DW-1:0]   ext_cmd_wdata,
  input  logic [DW/8-1:0] ext_cmd_wmask,
  output logic            ext_rsp_valid,
  input  logic            ext_rsp_ready,
  output logic [DW-1:0]   ext_rsp_rdata,
  output logic            dtcm_cmd_valid,
  input  logic            dtcm_cmd_ready,
  output logic            dtcm_cmd_read,
  output logic [AW-1:0]   dtcm_cmd_addr,
  output logic [DW-1:0]   dtcm_cmd_wdata,
  output logic [DW/8-1:0] dtcm_cmd_wmask,
  input  logic            dtcm_rsp_valid,
  output logic            dtcm_rsp_ready,
  input  logic [DW-1:0]   dtcm_rsp_rdata,
  output logic            err_orphan_rsp
);
  localparam int MW = DW / 8;
  localparam int PW = $clog2(OUTS_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic          read;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } cmd_t;

  cmd_t [1:0]         cmd_in;
  cmd_t               win_cmd;
  logic [1:0]         cmd_v, cmd_rdy, rsp_rdy_in, rsp_v, sel_rsp_rdy;
  logic [1:0][DW-1:0] rsp_rd;

  logic [OUTS_DEPTH-1:0] id_q, id_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  err_q, err_d;

  logic full, empty, any_v, win, cmd_go, push, pop, head_id, rsp_live;

  assign cmd_in[0]  = {lsu_cmd_read, lsu_cmd_addr, lsu_cmd_wdata, lsu_cmd_wmask};
  assign cmd_in[1]  = {ext_cmd_read, ext_cmd_addr, ext_cmd_wdata, ext_cmd_wmask};
  assign cmd_v      = {ext_cmd_valid, lsu_cmd_valid};
  assign rsp_rdy_in = {ext_rsp_ready, lsu_rsp_ready};

  // Full is taken from the registered count, so a pop never frees a slot for a same-cycle push.
  assign full  = (cnt_q == CW'(OUTS_DEPTH));
  assign empty = (cnt_q == '0);
  assign any_v = |cmd_v;

  always_comb begin
    win = 1'b0;
    if (&cmd_v)       win = ~last_gnt_q;
    else if (cmd_v[1]) win = 1'b1;
  end

  assign win_cmd        = cmd_in[win];
  assign cmd_go         = any_v & ~full & dtcm_cmd_ready;
  assign dtcm_cmd_valid = any_v & ~full;
  assign dtcm_cmd_read  = win_cmd.read;
  assign dtcm_cmd_addr  = win_cmd.addr;
  assign dtcm_cmd_wdata = win_cmd.wdata;
  assign dtcm_cmd_wmask = win_cmd.wmask;
  assign push           = dtcm_cmd_valid & dtcm_cmd_ready;

  assign head_id        = id_q[rd_ptr_q];
  assign rsp_live       = dtcm_rsp_valid & ~empty;
  assign dtcm_rsp_ready = ~empty & (|sel_rsp_rdy);
  assign pop            = dtcm_rsp_valid & dtcm_rsp_ready;

  for (genvar g = 0; g < 2; g++) begin : g_port
    dtcm_arb_port #(.DW(DW), .PORT_ID(g)) u_port (
      .win_id        (win),
      .cmd_go        (cmd_go),
      .head_id       (head_id),
      .rsp_live      (rsp_live),
      .rsp_rdata_in  (dtcm_rsp_rdata),
      .rsp_ready_in  (rsp_rdy_in[g]),
      .cmd_ready     (cmd_rdy[g]),
      .rsp_valid     (rsp_v[g]),
      .rsp_rdata     (rsp_rd[g]),
      .sel_rsp_ready (sel_rsp_rdy[g])
    );
  end

  assign lsu_cmd_ready  = cmd_rdy[0];
  assign ext_cmd_ready  = cmd_rdy[1];
  assign lsu_rsp_valid  = rsp_v[0];
  assign ext_rsp_valid  = rsp_v[1];
  assign lsu_rsp_rdata  = rsp_rd[0];
  assign ext_rsp_rdata  = rsp_rd[1];
  assign err_orphan_rsp = err_q;

  always_comb begin
    id_d       = id_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    err_d      = err_q | (dtcm_rsp_valid & empty);
    if (push) begin
      id_d[wr_ptr_q] = win;
      wr_ptr_d       = wr_ptr_q + PW'(1);
      last_gnt_d     = win;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      id_q       <= id_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_dtcm_arb.sv
// Bench for dtcm_arb: directed scenarios plus a randomized run against a queue-based reference model.
module tb_dtcm_arb;
  localparam int OUTS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_cmd_valid, lsu_cmd_read, lsu_rsp_ready;
  logic [15:0] lsu_cmd_addr;
  logic [31:0] lsu_cmd_wdata;
  logic [3:0]  lsu_cmd_wmask;
  logic        ext_cmd_valid, ext_cmd_read, ext_rsp_ready;
  logic [15:0] ext_cmd_addr;
  logic [31:0] ext_cmd_wdata;
  logic [3:0]  ext_cmd_wmask;
  logic        dtcm_cmd_ready, dtcm_rsp_valid;
  logic [31:0] dtcm_rsp_rdata;
  wire         lsu_cmd_ready, lsu_rsp_valid, ext_cmd_ready, ext_rsp_valid;
  wire  [31:0] lsu_rsp_rdata, ext_rsp_rdata, dtcm_cmd_wdata;
  wire         dtcm_cmd_valid, dtcm_cmd_read, dtcm_rsp_ready, err_orphan_rsp;
  wire  [15:0] dtcm_cmd_addr;
  wire  [3:0]  dtcm_cmd_wmask;

  int n_run  = 0;
  int n_fail = 0;

  // reference-model state for the randomized run
  int          mq[$];
  logic [31:0] dq[$];
  logic [31:0] iq0[$];
  logic [31:0] iq1[$];

  dtcm_arb #(.AW(16), .DW(32), .OUTS_DEPTH(OUTS)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready), .lsu_cmd_read(lsu_cmd_read),
    .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
    .ext_cmd_valid(ext_cmd_valid), .ext_cmd_ready(ext_cmd_ready), .ext_cmd_read(ext_cmd_read),
    .ext_cmd_addr(ext_cmd_addr), .ext_cmd_wdata(ext_cmd_wdata), .ext_cmd_wmask(ext_cmd_wmask),
    .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready), .ext_rsp_rdata(ext_rsp_rdata),
    .dtcm_cmd_valid(dtcm_cmd_valid), .dtcm_cmd_ready(dtcm_cmd_ready), .dtcm_cmd_read(dtcm_cmd_read),
    .dtcm_cmd_addr(dtcm_cmd_addr), .dtcm_cmd_wdata(dtcm_cmd_wdata), .dtcm_cmd_wmask(dtcm_cmd_wmask),
    .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_ready(dtcm_rsp_ready), .dtcm_rsp_rdata(dtcm_rsp_rdata),
    .err_orphan_rsp(err_orphan_rsp)
  );

  always #5 clk = ~clk;

  task automatic idle();
    lsu_cmd_valid = 0; lsu_cmd_read = 1; lsu_cmd_addr = '0; lsu_cmd_wdata = '0; lsu_cmd_wmask = '0;
    ext_cmd_valid = 0; ext_cmd_read = 1; ext_cmd_addr = '0; ext_cmd_wdata = '0; ext_cmd_wmask = '0;
    lsu_rsp_ready = 0; ext_rsp_ready = 0;
    dtcm_cmd_ready = 0; dtcm_rsp_valid = 0; dtcm_rsp_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_run++;
    if ({dtcm_cmd_valid, lsu_cmd_ready, ext_cmd_ready, lsu_rsp_valid, ext_rsp_valid, dtcm_rsp_ready, err_orphan_rsp} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 0000000",
        {dtcm_cmd_valid, lsu_cmd_ready, ext_cmd_ready, lsu_rsp_valid, ext_rsp_valid, dtcm_rsp_ready, err_orphan_rsp});
    end
    dtcm_cmd_ready = 1; lsu_rsp_ready = 1; ext_rsp_ready = 1;
    #1;
    n_run++;
    if ({dtcm_cmd_valid, lsu_cmd_ready, ext_cmd_ready, dtcm_rsp_ready} !== 4'b0) begin
      n_fail++; $display("FAIL reset_no_req_ready: got %b want 0000", {dtcm_cmd_valid, lsu_cmd_ready, ext_cmd_ready, dtcm_rsp_ready});
    end
  endtask

  task automatic test_single_read();
    do_reset();
    lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = 16'h0010; dtcm_cmd_ready = 1;
    #1;
    n_run++;
    if ({dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr, lsu_cmd_ready, ext_cmd_ready} !== {1'b1, 1'b1, 16'h0010, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL t1_cmd: got v=%b rd=%b addr=%h lrdy=%b erdy=%b want 1 1 0010 1 0",
        dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr, lsu_cmd_ready, ext_cmd_ready);
    end
    @(negedge clk);
    idle();
    lsu_rsp_ready = 1; dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'hDEADBEEF;
    #1;
    n_run++;
    if ({lsu_rsp_valid, lsu_rsp_rdata, ext_rsp_valid, dtcm_rsp_ready} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL t1_rsp: got lv=%b data=%h ev=%b rdy=%b want 1 deadbeef 0 1",
        lsu_rsp_valid, lsu_rsp_rdata, ext_rsp_valid, dtcm_rsp_ready);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_alternate();
    logic exp_lsu, prev_lsu;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      idle();
      if (i < 6) begin
        lsu_cmd_valid = 1; lsu_cmd_addr = 16'h0100;
        ext_cmd_valid = 1; ext_cmd_addr = 16'h0200;
      end
      dtcm_cmd_ready = 1; lsu_rsp_ready = 1; ext_rsp_ready = 1;
      dtcm_rsp_valid = (i > 0);
      dtcm_rsp_rdata = 32'hA000_0000 + i;
      #1;
      exp_lsu  = (i % 2 == 0);
      prev_lsu = ((i - 1) % 2 == 0);
      if (i < 6) begin
        n_run++;
        if ({lsu_cmd_ready, ext_cmd_ready, dtcm_cmd_addr} !== {exp_lsu, !exp_lsu, exp_lsu ? 16'h0100 : 16'h0200}) begin
          n_fail++; $display("FAIL t2_grant%0d: got lrdy=%b erdy=%b addr=%h want lsu=%b", i, lsu_cmd_ready, ext_cmd_ready, dtcm_cmd_addr, exp_lsu);
        end
      end
      if (i > 0) begin
        n_run++;
        if ({lsu_rsp_valid, ext_rsp_valid} !== {prev_lsu, !prev_lsu} ||
            (prev_lsu ? lsu_rsp_rdata : ext_rsp_rdata) !== 32'hA000_0000 + i) begin
          n_fail++; $display("FAIL t2_route%0d: got lv=%b ev=%b want lsu=%b", i, lsu_rsp_valid, ext_rsp_valid, prev_lsu);
        end
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_stall();
    do_reset();
    lsu_cmd_valid = 1; lsu_cmd_addr = 16'h0300;
    ext_cmd_valid = 1; ext_cmd_addr = 16'h0400;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_run++;
      if ({dtcm_cmd_valid, dtcm_cmd_addr, lsu_cmd_ready, ext_cmd_ready} !== {1'b1, 16'h0300, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL t3_stall%0d: got v=%b addr=%h lrdy=%b erdy=%b want 1 0300 0 0",
          i, dtcm_cmd_valid, dtcm_cmd_addr, lsu_cmd_ready, ext_cmd_ready);
      end
      @(negedge clk);
    end
    dtcm_cmd_ready = 1;
    #1;
    n_run++;
    if ({lsu_cmd_ready, ext_cmd_ready, dtcm_cmd_addr} !== {1'b1, 1'b0, 16'h0300}) begin
      n_fail++; $display("FAIL t3_release: got lrdy=%b erdy=%b addr=%h want 1 0 0300", lsu_cmd_ready, ext_cmd_ready, dtcm_cmd_addr);
    end
    @(negedge clk);
    lsu_cmd_valid = 0;
    #1;
    n_run++;
    if ({ext_cmd_ready, dtcm_cmd_addr} !== {1'b1, 16'h0400}) begin
      n_fail++; $display("FAIL t3_ext: got erdy=%b addr=%h want 1 0400", ext_cmd_ready, dtcm_cmd_addr);
    end
    @(negedge clk);
    idle();
    lsu_rsp_ready = 1; ext_rsp_ready = 1; dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h1;
    #1;
    n_run++;
    if ({lsu_rsp_valid, ext_rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL t3_rsp0: got lv=%b ev=%b want 1 0", lsu_rsp_valid, ext_rsp_valid);
    end
    @(negedge clk);
    dtcm_rsp_rdata = 32'h2;
    #1;
    n_run++;
    if ({lsu_rsp_valid, ext_rsp_valid, ext_rsp_rdata} !== {2'b01, 32'h2}) begin
      n_fail++; $display("FAIL t3_rsp1: got lv=%b ev=%b data=%h want 0 1 2", lsu_rsp_valid, ext_rsp_valid, ext_rsp_rdata);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_full();
    do_reset();
    dtcm_cmd_ready = 1; lsu_cmd_valid = 1;
    for (int i = 0; i < 2; i++) begin
      lsu_cmd_addr = 16'h0010 + 16'(4 * i);
      #1;
      n_run++;
      if (lsu_cmd_ready !== 1'b1) begin
        n_fail++; $display("FAIL t4_fill%0d: got lrdy=%b want 1", i, lsu_cmd_ready);
      end
      @(negedge clk);
    end
    lsu_cmd_addr = 16'h0018; ext_cmd_valid = 1; ext_cmd_addr = 16'h0020;
    #1;
    n_run++;
    if ({dtcm_cmd_valid, lsu_cmd_ready, ext_cmd_ready} !== 3'b000) begin
      n_fail++; $display("FAIL t4_blocked: got v=%b lrdy=%b erdy=%b want 000", dtcm_cmd_valid, lsu_cmd_ready, ext_cmd_ready);
    end
    @(negedge clk);
    dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'hC0DE0001; lsu_rsp_ready = 1;
    #1;
    n_run++;
    if ({lsu_rsp_valid, dtcm_rsp_ready, dtcm_cmd_valid, lsu_cmd_ready, ext_cmd_ready} !== 5'b11000) begin
      n_fail++; $display("FAIL t5_pop_no_push: got lv=%b rrdy=%b v=%b lrdy=%b erdy=%b want 11000",
        lsu_rsp_valid, dtcm_rsp_ready, dtcm_cmd_valid, lsu_cmd_ready, ext_cmd_ready);
    end
    @(negedge clk);
    dtcm_rsp_valid = 0;
    #1;
    n_run++;
    if ({dtcm_cmd_valid, ext_cmd_ready, lsu_cmd_ready, dtcm_cmd_addr} !== {3'b110, 16'h0020}) begin
      n_fail++; $display("FAIL t4_accept: got v=%b erdy=%b lrdy=%b addr=%h want 1 1 0 0020",
        dtcm_cmd_valid, ext_cmd_ready, lsu_cmd_ready, dtcm_cmd_addr);
    end
    @(negedge clk);
    idle();
    // FIFO holds {lsu, ext}; drain the LSU entry to leave room for push+pop traffic
    lsu_rsp_ready = 1; ext_rsp_ready = 1; dtcm_rsp_valid = 1;
    #1;
    n_run++;
    if ({lsu_rsp_valid, ext_rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL t4_drain: got lv=%b ev=%b want 1 0", lsu_rsp_valid, ext_rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int p;
    q.push_back(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle();
      p = i % 2;
      dtcm_cmd_ready = 1; lsu_rsp_ready = 1; ext_rsp_ready = 1;
      dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'hB0B0_0000 + i;
      if (i < 4) begin
        lsu_cmd_valid = (p == 0); lsu_cmd_addr = 16'(i);
        ext_cmd_valid = (p == 1); ext_cmd_addr = 16'(i);
      end
      #1;
      if (i < 4) begin
        n_run++;
        if ({lsu_cmd_ready, ext_cmd_ready} !== ((p == 0) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL b2b_push%0d: got lrdy=%b erdy=%b want port %0d", i, lsu_cmd_ready, ext_cmd_ready, p);
        end
      end
      n_run++;
      if ({lsu_rsp_valid, ext_rsp_valid} !== ((q[0] == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL b2b_route%0d: got lv=%b ev=%b want port %0d", i, lsu_rsp_valid, ext_rsp_valid, q[0]);
      end
      void'(q.pop_front());
      if (i < 4) q.push_back(p);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_orphan();
    do_reset();
    dtcm_rsp_valid = 1; lsu_rsp_ready = 1; ext_rsp_ready = 1;
    #1;
    n_run++;
    if ({dtcm_rsp_ready, lsu_rsp_valid, ext_rsp_valid, err_orphan_rsp} !== 4'b0000) begin
      n_fail++; $display("FAIL t6_orphan_comb: got rrdy=%b lv=%b ev=%b err=%b want 0000",
        dtcm_rsp_ready, lsu_rsp_valid, ext_rsp_valid, err_orphan_rsp);
    end
    @(negedge clk);
    dtcm_rsp_valid = 0;
    // leave the FIFO full so the reset has outstanding entries to discard
    dtcm_cmd_ready = 1; lsu_cmd_valid = 1;
    @(negedge clk);
    @(negedge clk);
    lsu_cmd_valid = 0;
    #1;
    n_run++;
    if (err_orphan_rsp !== 1'b1) begin
      n_fail++; $display("FAIL t6_sticky: got err=%b want 1", err_orphan_rsp);
    end
    do_reset();
    #1;
    n_run++;
    if (err_orphan_rsp !== 1'b0) begin
      n_fail++; $display("FAIL t6_err_clr: got err=%b want 0", err_orphan_rsp);
    end
    dtcm_cmd_ready = 1; ext_cmd_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_run++;
      if (ext_cmd_ready !== (i < 2)) begin
        n_fail++; $display("FAIL t6_count%0d: got erdy=%b want %b", i, ext_cmd_ready, (i < 2));
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_random();
    logic        p_v[2];
    logic        p_rd[2];
    logic [15:0] p_a[2];
    logic [31:0] p_wd[2];
    logic [3:0]  p_wm[2];
    logic        e_full, e_empty, e_cv, e_hs, e_rr;
    int          e_win, e_head, m_last;
    logic [1:0]  e_crdy, e_rv;
    logic [31:0] exp_d;
    do_reset();
    mq.delete(); dq.delete(); iq0.delete(); iq1.delete();
    m_last = 1;
    for (int p = 0; p < 2; p++) p_v[p] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!p_v[p] && $urandom_range(0, 2) != 0) begin
          p_v[p] = 1; p_rd[p] = 1'($urandom); p_a[p] = 16'($urandom);
          p_wd[p] = $urandom; p_wm[p] = 4'($urandom);
        end
      end
      lsu_cmd_valid = p_v[0]; lsu_cmd_read = p_rd[0]; lsu_cmd_addr = p_a[0]; lsu_cmd_wdata = p_wd[0]; lsu_cmd_wmask = p_wm[0];
      ext_cmd_valid = p_v[1]; ext_cmd_read = p_rd[1]; ext_cmd_addr = p_a[1]; ext_cmd_wdata = p_wd[1]; ext_cmd_wmask = p_wm[1];
      dtcm_cmd_ready = ($urandom_range(0, 3) != 0);
      lsu_rsp_ready  = ($urandom_range(0, 3) != 0);
      ext_rsp_ready  = ($urandom_range(0, 3) != 0);
      dtcm_rsp_valid = (dq.size() > 0) && ($urandom_range(0, 2) != 0);
      dtcm_rsp_rdata = dtcm_rsp_valid ? dq[0] : $urandom;
      #1;
      e_full  = (mq.size() >= OUTS);
      e_empty = (mq.size() == 0);
      if (p_v[0] && p_v[1]) e_win = (m_last == 0) ? 1 : 0;
      else                  e_win = p_v[1] ? 1 : 0;
      e_cv   = (p_v[0] || p_v[1]) && !e_full;
      e_hs   = e_cv && dtcm_cmd_ready;
      e_crdy = e_hs ? ((e_win == 1) ? 2'b10 : 2'b01) : 2'b00;
      e_head = e_empty ? 0 : mq[0];
      e_rv   = (dtcm_rsp_valid && !e_empty) ? ((e_head == 1) ? 2'b10 : 2'b01) : 2'b00;
      e_rr   = !e_empty && ((e_head == 1) ? ext_rsp_ready : lsu_rsp_ready);
      n_run++;
      if ({dtcm_cmd_valid, ext_cmd_ready, lsu_cmd_ready} !== {e_cv, e_crdy}) begin
        n_fail++; $display("FAIL rnd_cmd c%0d: got v=%b rdy=%b%b want v=%b rdy=%b",
          cyc, dtcm_cmd_valid, ext_cmd_ready, lsu_cmd_ready, e_cv, e_crdy);
      end
      if (e_cv) begin
        n_run++;
        if ({dtcm_cmd_read, dtcm_cmd_addr, dtcm_cmd_wdata, dtcm_cmd_wmask} !== {p_rd[e_win], p_a[e_win], p_wd[e_win], p_wm[e_win]}) begin
          n_fail++; $display("FAIL rnd_mux c%0d: got addr=%h want addr=%h port %0d", cyc, dtcm_cmd_addr, p_a[e_win], e_win);
        end
      end
      n_run++;
      if ({ext_rsp_valid, lsu_rsp_valid, dtcm_rsp_ready} !== {e_rv, e_rr}) begin
        n_fail++; $display("FAIL rnd_rsp c%0d: got v=%b%b rrdy=%b want v=%b rrdy=%b",
          cyc, ext_rsp_valid, lsu_rsp_valid, dtcm_rsp_ready, e_rv, e_rr);
      end
      if (e_rv != 2'b00) begin
        exp_d = (e_head == 1) ? iq1[0] : iq0[0];
        n_run++;
        if (((e_head == 1) ? ext_rsp_rdata : lsu_rsp_rdata) !== exp_d) begin
          n_fail++; $display("FAIL rnd_data c%0d: got %h want %h port %0d",
            cyc, (e_head == 1) ? ext_rsp_rdata : lsu_rsp_rdata, exp_d, e_head);
        end
      end
      if (dtcm_rsp_valid && e_rr) begin
        void'(mq.pop_front()); void'(dq.pop_front());
        if (e_head == 1) void'(iq1.pop_front()); else void'(iq0.pop_front());
      end
      if (e_hs) begin
        mq.push_back(e_win);
        m_last = e_win;
        dq.push_back({p_a[e_win], ~p_a[e_win]});
        if (e_win == 1) iq1.push_back({p_a[1], ~p_a[1]}); else iq0.push_back({p_a[0], ~p_a[0]});
        p_v[e_win] = 0;
      end
    end
    @(negedge clk);
    idle();
    #1;
    n_run++;
    if (err_orphan_rsp !== 1'b0) begin
      n_fail++; $display("FAIL rnd_no_orphan: got err=%b want 0", err_orphan_rsp);
    end
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_single_read();
    test_alternate();
    test_stall();
    test_full();
    test_back_to_back();
    test_orphan();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
